// File: rtl/chess_clock_core.sv
`default_nettype none
// ============================================================================
//  Module   : chess_clock_core
//  Brief    : N-player mm:ss chess clock with Fischer increment, pause/resume
//             and per-player flag-fall.
//  Revision : 1.0
// ============================================================================
module chess_clock_core #(
    parameter  int PLAYERS  = 2,
    parameter  int TICK_DIV = 100_000_000,
    parameter  int MAX_MIN  = 99,
    localparam int PW       = $clog2(PLAYERS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [6:0]             cfg_min,
    input  logic [5:0]             cfg_inc,
    input  logic                   cfg_load,
    input  logic                   start,
    input  logic                   pause,
    input  logic                   move_done,
    output logic [2:0]             state,
    output logic                   ready,
    output logic [PW-1:0]          active,
    output logic [7*PLAYERS-1:0]   min_flat,
    output logic [6*PLAYERS-1:0]   sec_flat,
    output logic [PLAYERS-1:0]     flag,
    output logic                   tick
);
    localparam int              C_PREW        = $clog2(TICK_DIV);
    localparam logic [C_PREW-1:0] C_PRE_LAST  = C_PREW'(TICK_DIV - 1);
    localparam logic [7:0]      C_MAX_MIN     = 8'(MAX_MIN);
    localparam logic [PW-1:0]   C_LAST_PLAYER = PW'(PLAYERS - 1);

    // Encoding is {ready, OVER, PAUSED, RUN} so outputs come straight off the register
    localparam logic [3:0] S_IDLE   = 4'b0000;
    localparam logic [3:0] S_READY  = 4'b1000;
    localparam logic [3:0] S_RUN    = 4'b0001;
    localparam logic [3:0] S_PAUSED = 4'b0010;
    localparam logic [3:0] S_OVER   = 4'b0100;

    logic [3:0]         r_fsm;
    logic [C_PREW-1:0]  r_pre;
    logic [5:0]         r_inc;
    logic [PW-1:0]      r_active;
    logic [PLAYERS-1:0] r_flag;
    logic               r_tick;
    logic [6:0]         r_min [PLAYERS];
    logic [5:0]         r_sec [PLAYERS];

    logic          w_run;
    logic          w_tick_now;
    logic          w_flag_fall;
    logic [6:0]    w_cur_min, w_dec_min, w_base_min, w_inc_min, w_load_min;
    logic [5:0]    w_cur_sec, w_dec_sec, w_base_sec, w_inc_sec, w_load_inc;
    logic [6:0]    w_sum_sec;
    logic [7:0]    w_carry_min;
    logic [PW-1:0] w_next_active;

    assign w_run         = (r_fsm == S_RUN);
    assign w_tick_now    = w_run && (r_pre == C_PRE_LAST);
    assign w_load_min    = (cfg_min > 7'(MAX_MIN)) ? 7'(MAX_MIN) : cfg_min;
    assign w_load_inc    = (cfg_inc > 6'd59) ? 6'd59 : cfg_inc;
    assign w_next_active = (r_active == C_LAST_PLAYER) ? '0 : r_active + 1'b1;

    // Tick decrement first, then the increment is applied on top of the result
    always_comb begin
        w_cur_min = r_min[r_active];
        w_cur_sec = r_sec[r_active];
        w_dec_min = w_cur_min;
        w_dec_sec = w_cur_sec;
        if (w_cur_sec != 6'd0) begin
            w_dec_sec = w_cur_sec - 6'd1;
        end else if (w_cur_min != 7'd0) begin
            w_dec_min = w_cur_min - 7'd1;
            w_dec_sec = 6'd59;
        end
        w_flag_fall = w_tick_now && (w_dec_min == 7'd0) && (w_dec_sec == 6'd0);
        w_base_min  = w_tick_now ? w_dec_min : w_cur_min;
        w_base_sec  = w_tick_now ? w_dec_sec : w_cur_sec;

        w_sum_sec   = {1'b0, w_base_sec} + {1'b0, r_inc};
        w_inc_sec   = w_sum_sec[5:0];
        w_carry_min = {1'b0, w_base_min};
        if (w_sum_sec >= 7'd60) begin
            w_inc_sec   = 6'(w_sum_sec - 7'd60);
            w_carry_min = {1'b0, w_base_min} + 8'd1;
        end
        w_inc_min = w_carry_min[6:0];
        if (w_carry_min > C_MAX_MIN) begin
            w_inc_min = C_MAX_MIN[6:0];
            w_inc_sec = 6'd59;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fsm    <= S_IDLE;
            r_pre    <= '0;
            r_inc    <= '0;
            r_active <= '0;
            r_flag   <= '0;
            r_tick   <= 1'b0;
            for (int i = 0; i < PLAYERS; i++) begin
                r_min[i] <= '0;
                r_sec[i] <= '0;
            end
        end else begin
            r_tick <= w_tick_now;
            if (w_run) begin
                if (w_flag_fall) begin
                    r_min[r_active]  <= '0;
                    r_sec[r_active]  <= '0;
                    r_flag[r_active] <= 1'b1;
                    r_pre            <= '0;
                    r_fsm            <= S_OVER;
                end else begin
                    if (move_done) begin
                        r_min[r_active] <= w_inc_min;
                        r_sec[r_active] <= w_inc_sec;
                        r_active        <= w_next_active;
                        r_pre           <= '0;
                    end else begin
                        r_min[r_active] <= w_base_min;
                        r_sec[r_active] <= w_base_sec;
                        r_pre           <= w_tick_now ? '0 : r_pre + 1'b1;
                    end
                    if (pause) begin
                        r_fsm <= S_PAUSED;
                    end
                end
            end else if (cfg_load && (cfg_min != 7'd0)) begin
                for (int i = 0; i < PLAYERS; i++) begin
                    r_min[i] <= w_load_min;
                    r_sec[i] <= '0;
                end
                r_inc    <= w_load_inc;
                r_active <= '0;
                r_flag   <= '0;
                r_pre    <= '0;
                r_fsm    <= S_READY;
            end else if (start && ((r_fsm == S_READY) || (r_fsm == S_PAUSED))) begin
                r_fsm <= S_RUN;
            end
        end
    end

    assign state  = r_fsm[2:0];
    assign ready  = r_fsm[3];
    assign active = r_active;
    assign flag   = r_flag;
    assign tick   = r_tick;

    for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_pack
        assign min_flat[7*gi +: 7] = r_min[gi];
        assign sec_flat[6*gi +: 6] = r_sec[gi];
    end
endmodule
`default_nettype wire
